// File: rtl/sgmii_link_pkg.sv
// Shared types and constants for the SGMII link monitor.
// Status-vector bit positions, FSM state encoding and speed codes.
package sgmii_link_pkg;

  typedef enum logic [1:0] {
    DOWN,
    DEBOUNCE,
    UP,
    RESTART
  } link_state_t;

  localparam int LINK       = 0;
  localparam int SYNC       = 1;
  localparam int DISPERR    = 5;
  localparam int NOTINTABLE = 6;
  localparam int PHY_LINK   = 7;
  localparam int SPEED_LO   = 10;
  localparam int SPEED_HI   = 11;
  localparam int DUPLEX     = 12;

  localparam logic [1:0] SPEED_10  = 2'b00;
  localparam logic [1:0] SPEED_100 = 2'b01;
  localparam logic [1:0] SPEED_1G  = 2'b10;

  // The reserved code 2'b11 is treated as 1G.
  function automatic logic [1:0] map_speed(input logic [1:0] s);
    return (s == 2'b11) ? SPEED_1G : s;
  endfunction

endpackage

// File: rtl/sgmii_link_monitor_sat_counter.sv
// Saturating up-counter with clear priority over increment.
// Ports: clock, reset_n (sync, active-low), clear, inc -> count.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/sgmii_link_monitor.sv
// Debounces SGMII link state, latches speed/duplex, restarts autoneg,
// counts code errors and raises a sticky link-event interrupt.
// Ports: clock, reset_n, status_vector, an_interrupt, irq_ack, err_clear
//   -> link_up, speed, full_duplex, speed_is_10_100, speed_is_100,
//      an_restart_config, irq, err_count.
module sgmii_link_monitor
  import sgmii_link_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES      = 125000,
  parameter int AN_TIMEOUT_CYCLES    = 250000000,
  parameter int RESTART_PULSE_CYCLES = 16,
  parameter int ERR_CNT_WIDTH        = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [15:0]              status_vector,
  input  logic                     an_interrupt,
  input  logic                     irq_ack,
  input  logic                     err_clear,
  output logic                     link_up,
  output logic [1:0]               speed,
  output logic                     full_duplex,
  output logic                     speed_is_10_100,
  output logic                     speed_is_100,
  output logic                     an_restart_config,
  output logic                     irq,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  localparam int DB_W =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TO_W =
    (AN_TIMEOUT_CYCLES > 1) ? $clog2(AN_TIMEOUT_CYCLES) : 1;
  localparam int RS_W =
    (RESTART_PULSE_CYCLES > 1) ? $clog2(RESTART_PULSE_CYCLES) : 1;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(AN_TIMEOUT_CYCLES - 1);
  localparam logic [RS_W-1:0] RS_LAST = RS_W'(RESTART_PULSE_CYCLES - 1);

  logic [15:0]     sv_q;
  logic            ani_q;
  logic            ani_prev_q;
  link_state_t     state_q, state_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [RS_W-1:0] rs_cnt_q, rs_cnt_d;
  logic [1:0]      speed_q, speed_d;
  logic            fdx_q, fdx_d;
  logic            irq_q, irq_d;
  logic            an_restart_q, an_restart_d;
  logic            irq_set;

  logic            link_ok;
  logic [1:0]      sv_speed;
  logic            sv_fdx;
  logic            code_err;
  logic            unused_sv;

  assign link_ok  = sv_q[LINK] & sv_q[SYNC] & sv_q[PHY_LINK];
  assign sv_speed = map_speed(sv_q[SPEED_HI:SPEED_LO]);
  assign sv_fdx   = sv_q[DUPLEX];
  assign code_err = sv_q[DISPERR] | sv_q[NOTINTABLE];
  assign unused_sv =
    ^{sv_q[15:13], sv_q[9:8], sv_q[4:2]};

  always_comb begin
    state_d  = state_q;
    db_cnt_d = db_cnt_q;
    to_cnt_d = to_cnt_q;
    rs_cnt_d = rs_cnt_q;
    speed_d  = speed_q;
    fdx_d    = fdx_q;
    irq_set  = ani_q & ~ani_prev_q;
    unique case (state_q)
      DOWN: begin
        if (link_ok) begin
          state_d  = DEBOUNCE;
          db_cnt_d = '0;
        end else if (to_cnt_q == TO_LAST) begin
          state_d  = RESTART;
          rs_cnt_d = '0;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (!link_ok) begin
          state_d  = DOWN;
          to_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d = UP;
          speed_d = sv_speed;
          fdx_d   = sv_fdx;
          irq_set = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      UP: begin
        if (!link_ok) begin
          state_d  = DOWN;
          to_cnt_d = '0;
          irq_set  = 1'b1;
        end else if ((sv_speed != speed_q) || (sv_fdx != fdx_q)) begin
          speed_d = sv_speed;
          fdx_d   = sv_fdx;
          irq_set = 1'b1;
        end
      end
      RESTART: begin
        if (rs_cnt_q == RS_LAST) begin
          state_d  = DOWN;
          to_cnt_d = '0;
        end else begin
          rs_cnt_d = rs_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = DOWN;
      end
    endcase
    irq_d        = irq_set ? 1'b1 : (irq_ack ? 1'b0 : irq_q);
    // Registered pulse: trails the RESTART state by one cycle.
    an_restart_d = (state_q == RESTART);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sv_q         <= '0;
      ani_q        <= 1'b0;
      ani_prev_q   <= 1'b0;
      state_q      <= DOWN;
      db_cnt_q     <= '0;
      to_cnt_q     <= '0;
      rs_cnt_q     <= '0;
      speed_q      <= SPEED_1G;
      fdx_q        <= 1'b1;
      irq_q        <= 1'b0;
      an_restart_q <= 1'b0;
    end else begin
      sv_q         <= status_vector;
      ani_q        <= an_interrupt;
      ani_prev_q   <= ani_q;
      state_q      <= state_d;
      db_cnt_q     <= db_cnt_d;
      to_cnt_q     <= to_cnt_d;
      rs_cnt_q     <= rs_cnt_d;
      speed_q      <= speed_d;
      fdx_q        <= fdx_d;
      irq_q        <= irq_d;
      an_restart_q <= an_restart_d;
    end
  end

  sat_counter #(
    .WIDTH(ERR_CNT_WIDTH)
  ) u_err_cnt (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (err_clear),
    .inc    (code_err),
    .count  (err_count)
  );

  assign link_up           = (state_q == UP);
  assign speed             = speed_q;
  assign full_duplex       = fdx_q;
  assign speed_is_10_100   = (speed_q != SPEED_1G);
  assign speed_is_100      = (speed_q == SPEED_100);
  assign an_restart_config = an_restart_q;
  assign irq               = irq_q;

endmodule
